// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory
// and queues {pc, instr} pairs in a 2-entry FIFO presented through valid/ready.
module instr_fetch #(
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        buf_count
);

  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] head_pc, head_pc_next, tail_pc, tail_pc_next;
  logic [DATA_W-1:0] head_instr, head_instr_next, tail_instr, tail_instr_next;
  logic [1:0]        count, count_next, fill;
  logic              pop, push;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head_pc;
  assign out_instr = head_instr;
  assign buf_count = count;

  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & ((count != 2'd2) | pop);
  // Slot the new entry lands in once this cycle's pop has been accounted for.
  assign fill = count - {1'b0, pop};

  always_comb begin
    pc_next         = pc;
    count_next      = count;
    head_pc_next    = head_pc;
    head_instr_next = head_instr;
    tail_pc_next    = tail_pc;
    tail_instr_next = tail_instr;

    if (pop && count == 2'd2) begin
      head_pc_next    = tail_pc;
      head_instr_next = tail_instr;
    end

    if (redirect_valid) begin
      pc_next    = redirect_pc;
      count_next = 2'd0;
    end else begin
      count_next = fill + {1'b0, push};
      if (push) begin
        pc_next = pc + ADDR_W'(1);
        if (fill == 2'd0) begin
          head_pc_next    = pc;
          head_instr_next = imem_instr;
        end else begin
          tail_pc_next    = pc;
          tail_instr_next = imem_instr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= ADDR_W'(RESET_PC);
      count      <= 2'd0;
      head_pc    <= '0;
      head_instr <= '0;
      tail_pc    <= '0;
      tail_instr <= '0;
    end else begin
      pc         <= pc_next;
      count      <= count_next;
      head_pc    <= head_pc_next;
      head_instr <= head_instr_next;
      tail_pc    <= tail_pc_next;
      tail_instr <= tail_instr_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based fetch model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [4:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic [1:0]  buf_count;

  logic [31:0] mem [32];
  int          n_compared   = 0;
  int          n_mismatched = 0;

  int          m_pc;
  int          q_pc[$];
  logic [31:0] q_instr[$];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  instr_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .buf_count(buf_count)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_head(input string name, input int pc, input logic [31:0] instr);
    check_output({name, " valid"}, 32'(out_valid), 32'd1);
    check_output({name, " pc"}, 32'(out_pc), 32'(pc));
    check_output({name, " instr"}, out_instr, instr);
  endtask

  // Reference model: a plain queue of fetched pairs plus a PC, advanced each edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = 0;
        q_pc.delete();
        q_instr.delete();
      end else begin
        bit do_pop, do_push;
        do_pop  = (q_pc.size() != 0) && out_ready;
        do_push = fetch_en && !redirect_valid && (q_pc.size() < 2 || do_pop);
        if (do_pop) begin
          void'(q_pc.pop_front());
          void'(q_instr.pop_front());
        end
        if (redirect_valid) begin
          q_pc.delete();
          q_instr.delete();
          m_pc = int'(redirect_pc);
        end else if (do_push) begin
          q_pc.push_back(m_pc);
          q_instr.push_back(mem[m_pc]);
          m_pc = (m_pc + 1) % 32;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_output("model valid", 32'(out_valid), 32'(q_pc.size() != 0));
        check_output("model count", 32'(buf_count), 32'(q_pc.size()));
        check_output("model addr", 32'(imem_addr), 32'(m_pc));
        if (q_pc.size() != 0) begin
          check_output("model out_pc", 32'(out_pc), 32'(q_pc[0]));
          check_output("model out_instr", out_instr, q_instr[0]);
        end
      end
    end
  end

  task automatic apply_stimulus();
    // Reset state
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    check_output("reset valid", 32'(out_valid), 32'd0);
    check_output("reset count", 32'(buf_count), 32'd0);
    check_output("reset out_pc", 32'(out_pc), 32'd0);
    check_output("reset out_instr", out_instr, 32'd0);
    check_output("reset addr", 32'(imem_addr), 32'd0);

    // Streaming from reset, no bubbles
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    tick(); check_head("stream0", 0, 32'h00110000);
    tick(); check_head("stream1", 1, 32'h00220001);
    tick(); check_head("stream2", 2, 32'h00330002);

    // Backpressure: buffer fills, pc stops at 2, then drains in order
    rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
    repeat (5) tick();
    check_output("stall count", 32'(buf_count), 32'd2);
    check_output("stall addr", 32'(imem_addr), 32'd2);
    check_head("stall head", 0, 32'h00110000);
    out_ready = 1'b1;
    tick(); check_head("drain1", 1, 32'h00220001);
    tick(); check_head("drain2", 2, 32'h00330002);
    tick(); check_head("drain3", 3, 32'h00440003);

    // PC wrap 31 -> 0
    redirect_valid = 1'b1; redirect_pc = 5'd29;
    tick(); redirect_valid = 1'b0;
    check_output("wrap flush valid", 32'(out_valid), 32'd0);
    tick(); check_output("wrap pc29", 32'(out_pc), 32'd29);
    tick(); check_output("wrap pc30", 32'(out_pc), 32'd30);
    tick(); check_output("wrap pc31", 32'(out_pc), 32'd31);
    tick(); check_head("wrap pc0", 0, 32'h00110000);

    // Redirect with concurrent pop, buffer holding pcs 3 and 4
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 5'd3;
    tick(); redirect_valid = 1'b0;
    repeat (2) tick();
    check_output("redir count", 32'(buf_count), 32'd2);
    check_head("redir head", 3, 32'h00440003);
    check_output("redir addr", 32'(imem_addr), 32'd5);
    redirect_valid = 1'b1; redirect_pc = 5'd1; out_ready = 1'b1;
    tick(); redirect_valid = 1'b0;
    check_output("redir bubble", 32'(out_valid), 32'd0);
    check_output("redir addr1", 32'(imem_addr), 32'd1);
    tick(); check_head("redir t1", 1, 32'h00220001);
    tick(); check_head("redir t2", 2, 32'h00330002);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 5'd5;
    tick(); redirect_valid = 1'b0;
    repeat (2) tick();
    check_output("pre-rst count", 32'(buf_count), 32'd2);
    check_output("pre-rst addr", 32'(imem_addr), 32'd7);
    #2 rst = 1'b1;
    #1;
    check_output("async valid", 32'(out_valid), 32'd0);
    check_output("async count", 32'(buf_count), 32'd0);
    check_output("async out_pc", 32'(out_pc), 32'd0);
    check_output("async addr", 32'(imem_addr), 32'd0);
    tick(); rst = 1'b0; out_ready = 1'b1;
    tick(); check_head("resume", 0, 32'h00110000);

    // fetch_en low: buffer drains, pc holds, then resumes
    out_ready = 1'b0;
    repeat (2) tick();
    check_output("fe count", 32'(buf_count), 32'd2);
    check_output("fe addr", 32'(imem_addr), 32'd2);
    fetch_en = 1'b0; out_ready = 1'b1;
    tick(); check_head("fe drain", 1, 32'h00220001);
    check_output("fe count1", 32'(buf_count), 32'd1);
    repeat (2) tick();
    check_output("fe empty", 32'(out_valid), 32'd0);
    check_output("fe hold addr", 32'(imem_addr), 32'd2);
    fetch_en = 1'b1;
    tick(); check_head("fe resume", 2, 32'h00330002);

    // Randomized traffic, including rare asynchronous resets
    repeat (3000) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 4) < 3);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end
    fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h00110000 * (i + 1) + i;
    for (int i = 5; i < 32; i++) mem[i] = mem[i] ^ {$urandom_range(0, 255), 24'h0};
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch unit that reads the combinational instruction memory (5-bit word address, 32-bit instruction, same-cycle read data).
- Holds the program counter, drives the memory address, and captures {pc, instr} pairs into a 2-entry buffer.
- Presents the buffer head to decode through a valid/ready handshake.
- Supports pipeline stall, fetch enable, and branch/jump redirect with buffer flush.

Parameters:
- ADDR_W, 5, PC / memory word-address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch permitted this cycle.
- imem_addr  out  ADDR_W  word address to instruction memory; equals the PC register.
- imem_instr  in  DATA_W  instruction read combinationally at imem_addr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  PC of head instruction.
- buf_count  out  2  buffer occupancy, 0..2.

Behaviour:
- Reset (async assert, any cycle, including mid-stream):
  - pc = RESET_PC, buffer emptied, buf_count = 0.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - imem_addr = RESET_PC immediately.
- imem_addr = pc register (registered output, no combinational path from inputs).
- pop = out_valid & out_ready.
- push = fetch_en & !redirect_valid & (buf_count < 2 | pop).
- On push:
  - Write {pc, imem_instr} at the buffer tail.
  - pc <= pc + 1, truncated to ADDR_W, so 31 -> 0 wraps with no flag.
- No push: pc holds.
- Buffer is a 2-entry FIFO, in-order.
  - out_valid = (buf_count != 0).
  - out_instr / out_pc are the head entry, stable while out_valid & !out_ready.
  - When empty, out_instr / out_pc hold their last value. The bench must not check them while out_valid = 0.
- Simultaneous push and pop at buf_count = 2: legal; count stays 2 and order is preserved.
- Push and pop at count 1: count stays 1; the new entry becomes head on the next cycle.
- Redirect (redirect_valid = 1 at a clock edge), highest priority:
  - Buffer flushed, buf_count <= 0, out_valid <= 0 next cycle.
  - A concurrent pop still completes; decode consumes that head.
  - pc <= redirect_pc.
  - No push that cycle, even with fetch_en = 1.
- Redirect with fetch_en = 0: flush and PC load still occur.
- Latency:
  - Memory address to buffered instruction: 1 cycle.
  - First out_valid: first edge after rst deasserts, with fetch_en = 1.
  - Redirect to first valid target instruction: 2 edges (load PC, then push).
- Throughput: 1 instruction/cycle sustained while out_ready = 1.
- fetch_en = 0: no push; buffer continues draining.
- No X propagation: all state registers reset.

Test Plan:
- Memory image word0 = 0x00110000, word1 = 0x00220001, word2 = 0x00330002, word3 = 0x00440003, word4 = 0x00550004. Release reset, fetch_en = 1, out_ready = 1 -> out_valid rises after 1 edge; (out_pc, out_instr) = (0, 0x00110000), (1, 0x00220001), (2, 0x00330002) … on consecutive cycles, with no bubbles.
- Same image, out_ready = 0 for 5 cycles -> buf_count reaches 2 and pc stops at 2; head stays (0, 0x00110000). Raise out_ready -> sequence 0, 1, 2, 3 with no loss or duplication.
- Steady flow through pc = 30, 31 -> next out_pc = 0 with word0; no stall at the wrap.
- Buffer holding pcs 3 and 4; assert redirect_valid with redirect_pc = 1 and out_ready = 1 in the same cycle -> entry 3 is consumed, entry 4 is discarded; out_valid = 0 for 1 cycle; then (1, 0x00220001), then (2, 0x00330002).
- Assert rst mid-stream (buf_count = 2, pc = 7) -> out_valid, buf_count and out_pc drop to 0 and imem_addr = 0 immediately; after release, resume at pc 0.
- fetch_en = 0 with 2 entries buffered, out_ready = 1 -> both entries drain, then out_valid = 0 and pc holds. Re-enable -> fetch resumes at the held pc.
